// File: rtl/tbus_arb_pkg.sv
// tbus_arb_pkg: shared definitions for the tristate-bus arbiter.
//   state_e     - arbiter FSM state encoding (2 bits)
//   *_DEFAULT   - default parameter values for tbus_arbiter
//   cnt_width() - width of a saturating counter that must reach max_val
package tbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int N_DEFAULT       = 4;
  localparam int MAXHOLD_DEFAULT = 8;
  localparam int GAP_DEFAULT     = 1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tbus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   REQ   [N]  - request vector
//   PTR   [OW] - index that has highest priority this round
//   VALID      - any request set
//   IDX   [OW] - first set REQ bit at or after PTR, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int OW = $clog2(N)
) (
  input  logic [N-1:0]  REQ,
  input  logic [OW-1:0] PTR,
  output logic          VALID,
  output logic [OW-1:0] IDX
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [OW:0]    sum;

  // Rotating a doubled copy puts requester PTR at bit 0, so the lowest set
  // bit of req_rot is the round-robin winner.
  assign req_dbl = {REQ, REQ};
  assign req_rot = N'(req_dbl >> PTR);

  always_comb begin
    VALID = 1'b0;
    IDX   = '0;
    sum   = '0;
    // Scan from the far end so the lowest offset is the final assignment.
    for (int off = N - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        sum = {1'b0, PTR} + (OW+1)'(off);
        if (sum >= (OW+1)'(N)) begin
          sum = sum - (OW+1)'(N);
        end
        VALID = 1'b1;
        IDX   = sum[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// tbus_arbiter: round-robin arbiter for a shared tristate bus of ivt1
// drivers. At most one GNT bit is ever high; tenures are capped at MAXHOLD
// cycles and separated by GAP all-off cycles plus one arbitration cycle.
//   CK    - clock, rising edge
//   R     - asynchronous active-high reset
//   REQ   - per-requester level request
//   GNT   - registered one-hot-or-zero enables (ivt1 E pins)
//   BUSY  - registered, high when any GNT bit is high
//   OWNER - registered index of the current or last grantee
// Build option: TBUS_ARB_PRIO0_EN gives requester 0 absolute priority at
// each arbitration (its tenure is still capped and followed by the gap).
//
// state | meaning
// IDLE  | bus free, pick a winner from REQ starting at PTR
// GRANT | GNT[OWNER] high, counting hold cycles
// TURN  | all GNT low for GAP cycles, REQ ignored
module tbus_arbiter
  import tbus_arb_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int MAXHOLD = MAXHOLD_DEFAULT,
  parameter int GAP     = GAP_DEFAULT,
  parameter int OW      = $clog2(N)
) (
  input  logic          CK,
  input  logic          R,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic          BUSY,
  output logic [OW-1:0] OWNER
);

  localparam int HW = cnt_width(MAXHOLD);
  localparam int GW = cnt_width(GAP);

  state_e        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [OW-1:0] owner_q, owner_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          win_valid;
  logic [OW-1:0] win_idx;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .REQ   (REQ),
    .PTR   (ptr_q),
    .VALID (pick_valid),
    .IDX   (pick_idx)
  );

`ifdef TBUS_ARB_PRIO0_EN
  // REQ[0] set implies pick_valid, so only the index needs overriding.
  assign win_valid = pick_valid;
  assign win_idx   = REQ[0] ? '0 : pick_idx;
`else
  assign win_valid = pick_valid;
  assign win_idx   = pick_idx;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_valid) begin
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          hold_d         = HW'(1);
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (REQ[owner_q] && (hold_q < HW'(MAXHOLD))) begin
          hold_d = hold_q + HW'(1);
        end else begin
          gnt_d   = '0;
          ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          gap_d   = GW'(1);
          state_d = TURN;
        end
      end
      TURN: begin
        gnt_d = '0;
        if (gap_q == GW'(GAP)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign GNT   = gnt_q;
  assign BUSY  = busy_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter (N=4, MAXHOLD=8, GAP=1). The stimulus
// process queues the tenures it expects (owner, length, zero cycles before
// it); the monitor pops one at each new grant and checks it.
module tb_tbus_arbiter;

  logic       CK;
  logic       R;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       BUSY;
  logic [1:0] OWNER;

  tbus_arbiter #(.N(4), .MAXHOLD(8), .GAP(1)) dut (
    .CK    (CK),
    .R     (R),
    .REQ   (REQ),
    .GNT   (GNT),
    .BUSY  (BUSY),
    .OWNER (OWNER)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    int owner;
    int len;
    int gap;   // all-zero GNT cycles before this tenure; -1 = do not check
  } exp_t;

  exp_t sb[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  // 1: track tenures, 2: expect reset/idle values, 3: final drain check
  int   mode   = 2;
  bit   done   = 1'b0;

  logic [3:0] prev_gnt   = '0;
  int         run_len    = 0;
  int         zero_run   = 0;
  int         last_owner = 0;
  exp_t       cur        = '{owner: 0, len: 0, gap: -1};

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge CK) begin
    if (mode == 2) begin
      chk("rst_gnt", int'(GNT), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_owner", int'(OWNER), 0);
      prev_gnt   = '0;
      run_len    = 0;
      zero_run   = 0;
      last_owner = 0;
    end else if (mode == 1) begin
      chk("onehot0", int'($countones(GNT) <= 1), 1);
      chk("busy_vs_gnt", int'(BUSY), int'(GNT != 4'b0000));
      if (GNT != 4'b0000) begin
        if (prev_gnt == 4'b0000) begin
          if (sb.size() == 0) begin
            chk("unexpected_grant", int'(GNT), 0);
          end else begin
            cur = sb.pop_front();
            chk("grant_vec", int'(GNT), 1 << cur.owner);
            chk("owner", int'(OWNER), cur.owner);
            if (cur.gap >= 0) chk("gap_cycles", zero_run, cur.gap);
            last_owner = cur.owner;
          end
          run_len = 1;
        end else begin
          chk("no_owner_switch", int'(GNT), int'(prev_gnt));
          run_len++;
        end
      end else begin
        if (prev_gnt != 4'b0000) begin
          chk("tenure_len", run_len, cur.len);
          zero_run = 1;
        end else begin
          zero_run++;
        end
        chk("owner_hold", int'(OWNER), last_owner);
      end
      prev_gnt = GNT;
    end else if (mode == 3 && !done) begin
      chk("sb_drained", sb.size(), 0);
      chk("final_gnt", int'(GNT), 0);
      done = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    R   = 1'b1;
    REQ = 4'b0000;
    mode = 2;
    cyc(3);
    R = 1'b0;
    // 20 idle cycles with no request: outputs stay at reset values
    cyc(20);
    mode = 1;

    // REQ[0] for 3 cycles, REQ[3] throughout; requester 3 then releases
    // after 5 cycles of tenure
    sb.push_back('{owner: 0, len: 3, gap: -1});
    sb.push_back('{owner: 3, len: 5, gap: 2});
    REQ = 4'b1001;
    cyc(3);
    REQ = 4'b1000;
    cyc(7);
    REQ = 4'b0000;
    cyc(4);

    // all requesting: 0,1,2,3,0, each capped at 8 with 2 zero cycles between
    sb.push_back('{owner: 0, len: 8, gap: -1});
    sb.push_back('{owner: 1, len: 8, gap: 2});
    sb.push_back('{owner: 2, len: 8, gap: 2});
    sb.push_back('{owner: 3, len: 8, gap: 2});
    sb.push_back('{owner: 0, len: 8, gap: 2});
    REQ = 4'b1111;
    cyc(49);
    REQ = 4'b0000;
    cyc(5);

    // REQ[1] drops exactly when its hold count hits 8; next pick must start
    // at PTR=2 (REQ 0 and 2 pending -> 2 wins)
    sb.push_back('{owner: 1, len: 8, gap: -1});
    sb.push_back('{owner: 2, len: 3, gap: 2});
    REQ = 4'b0010;
    cyc(8);
    REQ = 4'b0101;
    cyc(5);
    REQ = 4'b0000;
    cyc(4);

    // reset mid-tenure: GNT must clear before the next clock edge
    sb.push_back('{owner: 1, len: 0, gap: -1});
    REQ = 4'b0010;
    cyc(2);
    #1;
    R    = 1'b1;
    mode = 2;
    #5;
    R    = 1'b0;
    REQ  = 4'b0100;
    sb.push_back('{owner: 2, len: 2, gap: -1});
    mode = 1;
    cyc(2);
    REQ = 4'b0000;
    cyc(4);

    // REQ 0 and 1 held, PTR=3 at start
`ifdef TBUS_ARB_PRIO0_EN
    sb.push_back('{owner: 0, len: 8, gap: -1});
    sb.push_back('{owner: 0, len: 8, gap: 2});
    sb.push_back('{owner: 0, len: 8, gap: 2});
`else
    sb.push_back('{owner: 0, len: 8, gap: -1});
    sb.push_back('{owner: 1, len: 8, gap: 2});
    sb.push_back('{owner: 0, len: 8, gap: 2});
`endif
    REQ = 4'b0011;
    cyc(29);
    REQ = 4'b0000;
    cyc(5);

    mode = 3;
    for (int i = 0; i < 10 && !done; i++) cyc(1);
    if (!done) begin
      $display("FAIL final_check: monitor did not complete final check");
      $fatal(1, "final check timeout");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
